// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: the serial line plus the byte/strobe outputs and an FSM debug view.
// master is the receiver itself; slave is the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_busy;
  logic [2:0] dbg_state;

  // Strobe semantics: rx_vld, rx_ferr and rx_perr are single-cycle and mutually exclusive.
  // There is no ready/backpressure; the consumer must take rx_data in the rx_vld cycle.
  modport master (
    input  rx,
    output rx_data, rx_vld, rx_ferr, rx_perr, rx_busy, dbg_state
  );

  modport slave (
    output rx,
    input  rx_data, rx_vld, rx_ferr, rx_perr, rx_busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for start + 8 data + even parity + stop.
// Samples each bit at its midpoint using a 16-bit bit-timer driven from a two-flop synchronized rx.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t      state;
  logic        rx_q1;
  logic        rx_s;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic [7:0]  data_q;
  logic        vld_q;
  logic        ferr_q;
`ifdef UART_RX_PARITY_EN
  logic        perr_q;
  logic        par_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      rx_q1  <= bus.rx;
      rx_s   <= rx_q1;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= '0;
          end
        end
        // Re-check the start bit at its midpoint so short glitches are rejected.
        START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (timer == BIT_M1) begin
            timer <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == BIT_M1) begin
            timer   <= '0;
            par_bad <= ^{shift, rx_s};
            state   <= STOP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
`endif
        // Leaving mid-stop-bit lets a back-to-back start edge be caught in IDLE.
        STOP: begin
          if (timer == BIT_M1) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                perr_q <= 1'b1;
              end else begin
                data_q <= shift;
                vld_q  <= 1'b1;
              end
`else
              data_q <= shift;
              vld_q  <= 1'b1;
`endif
            end else begin
              ferr_q <= 1'b1;
              state  <= WAIT_HIGH;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_vld    = vld_q;
  assign bus.rx_ferr   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_perr   = perr_q;
`else
  assign bus.rx_perr   = 1'b0;
`endif
  assign bus.rx_busy   = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=100: good frames, glitch, break, back-to-back, mid-frame reset,
// and (with UART_RX_PARITY_EN) parity good/bad frames.
module tb_uart_rx;
  localparam int CPB = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  int         n_vld  = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         t_fall = 0;
  int         lat    = -1;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_vld || bus.rx_ferr || bus.rx_perr)
        check("strobe_excl", 32'($countones({bus.rx_vld, bus.rx_ferr, bus.rx_perr})), 32'd1);
      if (bus.rx_vld) begin
        n_vld++;
        lat = cyc - t_fall;
        if (exp_q.size() == 0) check("vld_unexpected", 32'd1, 32'd0);
        else                   check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
      if (bus.rx_ferr) n_ferr++;
      if (bus.rx_perr) n_perr++;
      if (bus.rx_data != prev_data) check("data_only_on_vld", 32'(bus.rx_vld), 32'd1);
    end
    prev_data = bus.rx_data;
  end

  // driver tasks: all called while positioned at a negedge
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) bus.rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  int v0, f0, p0;
  task automatic snap();
    v0 = n_vld; f0 = n_ferr; p0 = n_perr;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int df, input int dp);
    check({tag, "_vld_cnt"},  32'(n_vld - v0),  32'(dv));
    check({tag, "_ferr_cnt"}, 32'(n_ferr - f0), 32'(df));
    check({tag, "_perr_cnt"}, 32'(n_perr - p0), 32'(dp));
  endtask

`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
  localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

  initial begin
    int k;
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_rx_vld",  32'(bus.rx_vld),  32'd0);
    check("rst_rx_ferr", 32'(bus.rx_ferr), 32'd0);
    check("rst_rx_perr", 32'(bus.rx_perr), 32'd0);
    check("rst_rx_busy", 32'(bus.rx_busy), 32'd0);
    rst = 1'b0;
    idle(20);

    // single good frame 8'hA5 and its latency
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(2 * CPB);
    check_deltas("a5", 1, 0, 0);
    check("a5_rx_data", 32'(bus.rx_data), 32'hA5);
    check("a5_latency_in_window", 32'((lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)), 32'd1);

    // 20-cycle low glitch
    snap();
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_set", 32'(bus.rx_busy), 32'd1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    k = 0;
    while (bus.rx_busy && k < 52) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_clear", 32'(bus.rx_busy), 32'd0);
    idle(2 * CPB);
    check_deltas("glitch", 0, 0, 0);

    // bad stop bit on 8'h3C followed by a long break, from a fresh reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(10);
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check("break_busy", 32'(bus.rx_busy), 32'd1);
    idle(3 * CPB);
    check_deltas("break", 0, 1, 0);
    check("break_rx_data", 32'(bus.rx_data), 32'h00);
    check("break_busy_clear", 32'(bus.rx_busy), 32'd0);

    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(2 * CPB);
    check_deltas("after_break", 1, 0, 0);
    check("after_break_rx_data", 32'(bus.rx_data), 32'h5A);

    // back-to-back frames
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(2 * CPB);
    check_deltas("b2b", 3, 0, 0);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_rx_data", 32'(bus.rx_data), 32'h81);

    // reset in the middle of data bit 4 of 8'hC3
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(bit'((8'hC3 >> i) & 8'h01));
    bus.rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
    check("midrst_busy", 32'(bus.rx_busy), 32'd0);
    bus.rx = 1'b1;
    rst    = 1'b0;
    idle(12 * CPB);
    check_deltas("midrst", 0, 0, 0);
    snap();
    exp_q.push_back(8'h81);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(2 * CPB);
    check_deltas("after_midrst", 1, 0, 0);
    check("after_midrst_rx_data", 32'(bus.rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    // parity: 8'h07 has three ones, so the even-parity bit is 1
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    check_deltas("par_good", 1, 0, 0);
    check("par_good_rx_data", 32'(bus.rx_data), 32'h07);

    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2 * CPB);
    check_deltas("par_bad", 0, 0, 1);
    check("par_bad_rx_data", 32'(bus.rx_data), 32'h07);

    snap();
    send_frame(8'h07, 1'b0, 1'b0);
    idle(3 * CPB);
    check_deltas("par_bad_stop_bad", 0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
